// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared definitions for the digital clock timekeeping core.
//   Contents:
//     mode_t        : set-mode encodings (MODE_RUN, MODE_SET_HR, MODE_SET_MIN)
//     *_MAX         : field limits for seconds, minutes and both hour formats
//     clog2         : register width needed to count 0..value-1 (minimum 1)
//     to_bcd8       : converts a 0..99 integer constant to packed two-digit BCD
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;

  function automatic int clog2(input longint value);
    int width;
    width = 1;
    while ((longint'(1) << width) < value) width++;
    return width;
  endfunction

  function automatic logic [7:0] to_bcd8(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Two-digit BCD counter that counts 00..MAX and wraps back to 00.
//   Ports:
//     clk_in  in   1  clock, rising edge
//     rst_n   in   1  synchronous active-low reset
//     clr     in   1  synchronous clear to 00 (dominates inc)
//     inc     in   1  advance by one
//     value   out  8  {tens, ones} BCD
//     carry   out  1  high in the cycle an inc wraps MAX -> 00
//   Parameter MAX: terminal value as a decimal integer (e.g. 59).
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = to_bcd8(MAX);

  logic at_max;

  assign at_max = (value == MAX_BCD);

  // Carry is combinational so a whole chain of wraps lands on one edge.
  assign carry = inc && !clr && at_max;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (at_max) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Timekeeping core: divides the board clock to a tick, keeps HH:MM:SS in
//   BCD and lets the user set hours/minutes with a mode and an inc button.
//   Ports:
//     clk_in    in   1  board clock
//     rst_n     in   1  synchronous active-low reset
//     btn_mode  in   1  debounced level; rising edge steps RUN->SET_HR->SET_MIN->RUN
//     btn_inc   in   1  debounced level; rising edge increments the field being set
//     d3..d0    out  4  hours tens/ones, minutes tens/ones (BCD)
//     sec_bcd   out  8  seconds {tens, ones} BCD
//     tick      out  1  one-cycle pulse per prescaler wrap
//     colon     out  1  high during the first half of each tick period
//     mode      out  2  current mode_t
//     pm        out  1  PM flag (12 h build only, otherwise 0)
//   Build option: define TWELVE_HOUR_EN for the 12 h hours path with pm flag.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int INPUT_FREQ = 50000000,
  parameter int TICK_HZ    = 1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [7:0] sec_bcd,
  output logic       tick,
  output logic       colon,
  output logic [1:0] mode,
  output logic       pm
);

  localparam int TC = INPUT_FREQ / TICK_HZ - 1;
  localparam int PW = clog2(longint'(TC) + 1);
  localparam logic [PW-1:0] TC_W   = PW'(TC);
  localparam logic [PW-1:0] HALF_W = PW'((TC + 1) / 2);

`ifdef TWELVE_HOUR_EN
  localparam bit TWELVE = 1'b1;
`else
  localparam bit TWELVE = 1'b0;
`endif

  mode_t         state, state_next;
  logic [PW-1:0] presc;
  logic          btn_mode_q, btn_inc_q;
  logic          mode_edge, inc_edge, inc_ok;
  logic          tick_evt, hold_clr;
  logic          sec_carry, min_carry;
  logic          min_inc, hr_inc;
  logic [7:0]    min_bcd, hr_bcd;

  // Button edge registers: one pulse per press, however long it is held.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
    end
  end

  assign mode_edge = btn_mode && !btn_mode_q;
  assign inc_edge  = btn_inc && !btn_inc_q;
  // A simultaneous mode step swallows the increment.
  assign inc_ok    = inc_edge && !mode_edge;

  // Mode state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= MODE_RUN;
    else        state <= state_next;
  end

  // Mode sequencing on each btn_mode edge.
  always_comb begin
    state_next = state;
    if (mode_edge) begin
      case (state)
        MODE_RUN:    state_next = MODE_SET_HR;
        MODE_SET_HR: state_next = MODE_SET_MIN;
        default:     state_next = MODE_RUN;
      endcase
    end
  end

  // Leaving RUN (or being in a SET mode) pins the prescaler and seconds at 0,
  // so returning to RUN restarts a full tick period.
  assign hold_clr = (state != MODE_RUN) || mode_edge;
  assign tick_evt = !hold_clr && (presc == TC_W);

  // Prescaler and registered tick pulse.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= tick_evt;
      if (hold_clr || presc == TC_W) presc <= '0;
      else                           presc <= presc + PW'(1);
    end
  end

  assign colon = (presc < HALF_W);

  assign min_inc = (tick_evt && sec_carry) || (state == MODE_SET_MIN && inc_ok);
  assign hr_inc  = (tick_evt && min_carry) || (state == MODE_SET_HR && inc_ok);

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (hold_clr),
    .inc    (tick_evt),
    .value  (sec_bcd),
    .carry  (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (1'b0),
    .inc    (min_inc),
    .value  (min_bcd),
    .carry  (min_carry)
  );

  generate
    if (TWELVE) begin : g_hr12
      logic pm_q;

      // 12 h sequence 12,01..11 with pm flipping on every 11 -> 12 step.
      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          hr_bcd <= to_bcd8(HR12_MAX);
          pm_q   <= 1'b0;
        end else if (hr_inc) begin
          if (hr_bcd == to_bcd8(HR12_MAX)) begin
            hr_bcd <= 8'h01;
          end else if (hr_bcd == to_bcd8(HR12_MAX - 1)) begin
            hr_bcd <= to_bcd8(HR12_MAX);
            pm_q   <= !pm_q;
          end else if (hr_bcd[3:0] == 4'd9) begin
            hr_bcd <= 8'h10;
          end else begin
            hr_bcd <= {hr_bcd[7:4], hr_bcd[3:0] + 4'd1};
          end
        end
      end

      assign pm = pm_q;
    end else begin : g_hr24
      logic day_wrap;

      bcd_mod_counter #(.MAX(HR24_MAX)) u_hr (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (hr_inc),
        .value  (hr_bcd),
        .carry  (day_wrap)
      );

      // The day rollover has no consumer in the 24 h build; pm stays 0.
      assign pm = day_wrap & 1'b0;
    end
  endgenerate

  assign d3   = hr_bcd[7:4];
  assign d2   = hr_bcd[3:0];
  assign d1   = min_bcd[7:4];
  assign d0   = min_bcd[3:0];
  assign mode = state;

endmodule
